bus_xfer_arbiter: RTL

//  Round-robin arbiter/sequencer for the shared 32-bit datapath bus and its 5-bit source-select mux.

---
 rtl/bus_xfer_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/bus_xfer_arbiter.sv
// bus_xfer_arbiter
//   Round-robin arbiter and sequencer for the shared 32-bit datapath bus and
//   its 5-bit source-select mux. Each of NREQ requesters posts one transfer:
//   a source code and a destination register. The block drives the mux
//   select, waits one settle cycle, then pulses the destination load enable
//   and the grant. Every transfer is IDLE -> DRIVE -> LOAD (3 cycles).
//
//   Optional feature: define BUS_ARB_LOCK_EN to let the winner keep the bus
//   for up to 4 consecutive transfers through req_lock. Without the macro,
//   req_lock is ignored and arbitration is strict round-robin.
//
// Ports
//   clk       in   rising-edge clock
//   clr_n     in   asynchronous active-low reset
//   req       in   [NREQ]    pending-transfer flag per requester
//   req_src   in   [NREQ*5]  source code of requester i at [5i+4:5i]
//   req_dst   in   [NREQ*5]  destination index of requester i at [5i+4:5i]
//   req_lock  in   [NREQ]    keep the bus for the next transfer (lock build)
//   bus_sel   out  [5]       bus mux select, SEL_IDLE when no transfer
//   dst_ld    out  [NDST]    one-hot destination load pulse (LOAD only)
//   gnt       out  [NREQ]    one-hot completion pulse (LOAD only)
//   err       out            completed transfer had an illegal src or dst
//   busy      out            high in DRIVE and LOAD
module bus_xfer_arbiter #(
   parameter int         NREQ     = 4,
   parameter int         NSRC     = 24,
   parameter int         NDST     = 24,
   parameter logic [4:0] SEL_IDLE = 5'd31
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*5-1:0] req_src,
   input  logic [NREQ*5-1:0] req_dst,
   input  logic [NREQ-1:0]   req_lock,
   output logic [4:0]        bus_sel,
   output logic [NDST-1:0]   dst_ld,
   output logic [NREQ-1:0]   gnt,
   output logic              err,
   output logic              busy
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   state_t            state_q;
   logic [4:0]        src_q;
   logic [4:0]        dst_q;
   logic [IDW-1:0]    id_q;
   logic [IDW-1:0]    rr_ptr_q;
   logic [4:0]        bus_sel_q;
   logic [NDST-1:0]   dst_ld_q;
   logic [NREQ-1:0]   gnt_q;
   logic              err_q;
   logic              busy_q;

   logic [4:0]        src_arr [NREQ];
   logic [4:0]        dst_arr [NREQ];
   logic              win_vld_d;
   logic [IDW-1:0]    win_id_d;
   logic [IDW:0]      cand_d;
   logic [IDW-1:0]    ptr_nxt_d;
   logic              src_ok_d;
   logic              dst_ok_d;
   logic              win_src_ok_d;

   // Split the packed request buses into per-requester fields.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         src_arr[i] = req_src[5*i +: 5];
         dst_arr[i] = req_dst[5*i +: 5];
      end
   end

   // Winner search: first requesting index at or after rr_ptr, modulo NREQ.
   // NOTE: every combinational output gets a default before the loop so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      win_vld_d = 1'b0;
      win_id_d  = '0;
      cand_d    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_d = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (cand_d >= (IDW+1)'(NREQ)) begin
            cand_d = cand_d - (IDW+1)'(NREQ);
         end
         if (!win_vld_d && req[cand_d[IDW-1:0]]) begin
            win_vld_d = 1'b1;
            win_id_d  = cand_d[IDW-1:0];
         end
      end
   end

   assign ptr_nxt_d    = (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
   assign src_ok_d     = ({1'b0, src_q} < 6'(NSRC));
   assign dst_ok_d     = ({1'b0, dst_q} < 6'(NDST));
   assign win_src_ok_d = ({1'b0, src_arr[win_id_d]} < 6'(NSRC));

`ifdef BUS_ARB_LOCK_EN
   // lock_run_q counts locked transfers in the current chain; the fourth
   // transfer of a chain always advances the pointer.
   logic       lock_hold_q;
   logic [1:0] lock_run_q;
`else
   logic       unused_lock;
   assign unused_lock = ^req_lock;
`endif

   // Outputs are registered one state ahead: the values for DRIVE are
   // loaded on the IDLE->DRIVE edge, those for LOAD on DRIVE->LOAD.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= ST_IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         id_q      <= '0;
         rr_ptr_q  <= '0;
         bus_sel_q <= SEL_IDLE;
         dst_ld_q  <= '0;
         gnt_q     <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
`ifdef BUS_ARB_LOCK_EN
         lock_hold_q <= 1'b0;
         lock_run_q  <= '0;
`endif
      end else begin
         dst_ld_q <= '0;
         gnt_q    <= '0;
         err_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               bus_sel_q <= SEL_IDLE;
               busy_q    <= 1'b0;
`ifdef BUS_ARB_LOCK_EN
               // The lock owner sits at rr_ptr; if it is not asking, let go.
               if (lock_hold_q && !req[rr_ptr_q]) begin
                  lock_hold_q <= 1'b0;
                  lock_run_q  <= '0;
               end
`endif
               if (win_vld_d) begin
                  src_q     <= src_arr[win_id_d];
                  dst_q     <= dst_arr[win_id_d];
                  id_q      <= win_id_d;
                  bus_sel_q <= win_src_ok_d ? src_arr[win_id_d] : SEL_IDLE;
                  busy_q    <= 1'b1;
                  state_q   <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (src_ok_d && dst_ok_d) begin
                  dst_ld_q <= NDST'(1) << dst_q;
               end else begin
                  err_q <= 1'b1;
               end
               gnt_q   <= NREQ'(1) << id_q;
               state_q <= ST_LOAD;
            end
            ST_LOAD: begin
`ifdef BUS_ARB_LOCK_EN
               if (req_lock[id_q] && (lock_run_q != 2'd3)) begin
                  rr_ptr_q    <= id_q;
                  lock_hold_q <= 1'b1;
                  lock_run_q  <= lock_run_q + 2'd1;
               end else begin
                  rr_ptr_q    <= ptr_nxt_d;
                  lock_hold_q <= 1'b0;
                  lock_run_q  <= '0;
               end
`else
               rr_ptr_q <= ptr_nxt_d;
`endif
               bus_sel_q <= SEL_IDLE;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus_sel = bus_sel_q;
   assign dst_ld  = dst_ld_q;
   assign gnt     = gnt_q;
   assign err     = err_q;
   assign busy    = busy_q;

endmodule
